// File: rtl/elliptic_curve_structs.sv
// Shared types for the elliptic-curve point multiplier datapath and its job sequencer.
package elliptic_curve_structs;

  localparam int unsigned P_WIDTH   = 256;
  localparam int unsigned JOB_TAG_W = 8;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } point_t;

  typedef struct packed {
    logic [P_WIDTH-1:0]   px;
    logic [P_WIDTH-1:0]   py;
    logic [P_WIDTH-1:0]   k;
    logic [JOB_TAG_W-1:0] tag;
  } mul_job_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BLANK = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/point_mul_job_sequencer_job_fifo.sv
// Synchronous FIFO of mul_job_t; pointers carry an extra wrap bit to tell full from empty.
module job_fifo
  import elliptic_curve_structs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_push,
  input  mul_job_t i_data,
  input  logic     i_pop,
  output mul_job_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mul_job_t     r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/point_mul_job_sequencer.sv
// Feeds buffered (P, k, tag) jobs to one point multiplier via its start/done
// handshake and returns results in order on a valid/ready stream.
// Optional watchdog: define MUL_WATCHDOG_EN.
module point_mul_job_sequencer
  import elliptic_curve_structs::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [P_WIDTH-1:0] job_px,
  input  logic [P_WIDTH-1:0] job_py,
  input  logic [P_WIDTH-1:0] job_k,
  input  logic [TAG_W-1:0]   job_tag,
  output logic               mul_start,
  output logic [P_WIDTH-1:0] mul_px,
  output logic [P_WIDTH-1:0] mul_py,
  output logic [P_WIDTH-1:0] mul_k,
  input  logic               mul_done,
  input  logic [P_WIDTH-1:0] mul_rx,
  input  logic [P_WIDTH-1:0] mul_ry,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [P_WIDTH-1:0] res_rx,
  output logic [P_WIDTH-1:0] res_ry,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_err,
  output logic               busy
);

  mul_job_t                 w_job_in;
  mul_job_t                 w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;

  seq_state_t               r_state;
  seq_state_t               w_state_n;
  logic                     r_mul_start,  w_mul_start;
  logic [P_WIDTH-1:0]       r_mul_px,     w_mul_px;
  logic [P_WIDTH-1:0]       r_mul_py,     w_mul_py;
  logic [P_WIDTH-1:0]       r_mul_k,      w_mul_k;
  logic [JOB_TAG_W-1:0]     r_tag,        w_tag;
  logic                     r_res_valid,  w_res_valid;
  logic [P_WIDTH-1:0]       r_res_rx,     w_res_rx;
  logic [P_WIDTH-1:0]       r_res_ry,     w_res_ry;
  logic [TAG_W-1:0]         r_res_tag,    w_res_tag;

`ifdef MUL_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0]          r_wd_cnt,     w_wd_cnt_n;
  logic                     r_res_err,    w_res_err;
  assign res_err = r_res_err;
`else
  logic                     w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYC;
  assign res_err = 1'b0;
`endif

  assign w_job_in = '{px: job_px, py: job_py, k: job_k, tag: JOB_TAG_W'(job_tag)};

  job_fifo #(.DEPTH(FIFO_DEPTH)) u_job_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (job_valid && !w_full),
    .i_data  (w_job_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign job_ready = !w_full;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign mul_start = r_mul_start;
  assign mul_px    = r_mul_px;
  assign mul_py    = r_mul_py;
  assign mul_k     = r_mul_k;
  assign res_valid = r_res_valid;
  assign res_rx    = r_res_rx;
  assign res_ry    = r_res_ry;
  assign res_tag   = r_res_tag;

  // Next-state and next-output decode; Done is only sampled in WAIT.
  always_comb begin
    w_state_n   = r_state;
    w_pop       = 1'b0;
    w_mul_start = 1'b0;
    w_mul_px    = r_mul_px;
    w_mul_py    = r_mul_py;
    w_mul_k     = r_mul_k;
    w_tag       = r_tag;
    w_res_valid = r_res_valid;
    w_res_rx    = r_res_rx;
    w_res_ry    = r_res_ry;
    w_res_tag   = r_res_tag;
`ifdef MUL_WATCHDOG_EN
    w_res_err   = r_res_err;
    w_wd_cnt_n  = r_wd_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_mul_px    = w_head.px;
          w_mul_py    = w_head.py;
          w_mul_k     = w_head.k;
          w_tag       = w_head.tag;
          w_mul_start = 1'b1;
          w_state_n   = ST_START;
        end
      end
      ST_START: begin
        w_state_n = ST_BLANK;
`ifdef MUL_WATCHDOG_EN
        w_wd_cnt_n = '0;
`endif
      end
      ST_BLANK: begin
        // Done may still be high from the previous job here.
        w_state_n = ST_WAIT;
`ifdef MUL_WATCHDOG_EN
        w_wd_cnt_n = r_wd_cnt + WD_W'(1);
`endif
      end
      ST_WAIT: begin
        if (mul_done) begin
          w_res_rx    = mul_rx;
          w_res_ry    = mul_ry;
          w_res_tag   = TAG_W'(r_tag);
          w_res_valid = 1'b1;
`ifdef MUL_WATCHDOG_EN
          w_res_err   = 1'b0;
`endif
          w_state_n   = ST_HOLD;
        end
`ifdef MUL_WATCHDOG_EN
        else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
          w_res_rx    = '0;
          w_res_ry    = '0;
          w_res_tag   = TAG_W'(r_tag);
          w_res_valid = 1'b1;
          w_res_err   = 1'b1;
          w_state_n   = ST_HOLD;
        end else begin
          w_wd_cnt_n = r_wd_cnt + WD_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (res_ready) begin
          w_res_valid = 1'b0;
          w_state_n   = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mul_start <= 1'b0;
      r_mul_px    <= '0;
      r_mul_py    <= '0;
      r_mul_k     <= '0;
      r_tag       <= '0;
      r_res_valid <= 1'b0;
      r_res_rx    <= '0;
      r_res_ry    <= '0;
      r_res_tag   <= '0;
`ifdef MUL_WATCHDOG_EN
      r_res_err   <= 1'b0;
      r_wd_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_mul_start <= w_mul_start;
      r_mul_px    <= w_mul_px;
      r_mul_py    <= w_mul_py;
      r_mul_k     <= w_mul_k;
      r_tag       <= w_tag;
      r_res_valid <= w_res_valid;
      r_res_rx    <= w_res_rx;
      r_res_ry    <= w_res_ry;
      r_res_tag   <= w_res_tag;
`ifdef MUL_WATCHDOG_EN
      r_res_err   <= w_res_err;
      r_wd_cnt    <= w_wd_cnt_n;
`endif
    end
  end

endmodule

// File: doc/point_mul_job_sequencer.md
Name: point_mul_job_sequencer

Overview:
- Initiator side of the point multiplier's start/done protocol.
- Accepts (P, k, tag) jobs on a valid/ready input stream and buffers them in a small FIFO.
- For each job: drives a one-cycle start pulse into point_mul_double_and_add (its Reset input), holds P/k stable, waits for Done, captures R, and presents it on a valid/ready result stream.
- Sits between the MSM bucket scheduler and one multiplier instance.

Parameters:
- FIFO_DEPTH, 4, input job FIFO entries; power of two, ≥2
- TAG_W, 8, width of the opaque job tag carried through to the result
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  FIFO not full
- job_px  in  P_WIDTH  input point x
- job_py  in  P_WIDTH  input point y
- job_k  in  P_WIDTH  scalar
- job_tag  in  TAG_W  job tag
- mul_start  out  1  connects to the multiplier Reset (active-high start pulse)
- mul_px  out  P_WIDTH  multiplier P.x
- mul_py  out  P_WIDTH  multiplier P.y
- mul_k  out  P_WIDTH  multiplier k
- mul_done  in  1  multiplier Done
- mul_rx  in  P_WIDTH  multiplier R.x
- mul_ry  in  P_WIDTH  multiplier R.y
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_rx  out  P_WIDTH  result x
- res_ry  out  P_WIDTH  result y
- res_tag  out  TAG_W  tag of the job
- res_err  out  1  watchdog expired (always 0 without the optional feature)
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty; FSM in IDLE.
  - mul_start=0; mul_px/py/k=0.
  - res_valid=0; res_rx/ry/tag=0; res_err=0.
  - job_ready=1 once reset is released.
  - Reset mid-job abandons the job; no result is emitted.
- Input FIFO:
  - Push when job_valid && job_ready; job_ready = !full.
  - Push and pop in the same cycle are both allowed when full: job_ready stays 0 that cycle and the pop does not free a slot until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit to distinguish full from empty.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into mul_px/py/k and a tag register -> START.
  - START: mul_start=1 for exactly one cycle; operands are already stable this cycle -> BLANK.
  - BLANK: one cycle with mul_done ignored, because Done may still be high from the previous job -> WAIT.
  - WAIT: on mul_done=1, register mul_rx/ry into res_rx/ry, res_tag=tag, res_valid=1 -> HOLD.
  - HOLD: res_valid held with stable data until res_ready=1; on handshake res_valid=0 -> IDLE.
- Operands mul_px/py/k stay constant from START until leaving WAIT.
- Latency:
  - Job accepted into empty FIFO with FSM in IDLE -> mul_start asserted 2 cycles later (1 cycle FIFO write, 1 cycle IDLE pop).
  - mul_done seen in WAIT -> res_valid the next cycle.
- No new job starts while in HOLD; results are therefore always in order.
- mul_done asserted during START/BLANK is ignored; only its level in WAIT counts.
- res_ready asserted while res_valid=0 has no effect.

Optional Feature:
- Macro: MUL_WATCHDOG_EN.
- With the macro defined:
  - A counter is cleared in START and increments each cycle in BLANK/WAIT.
  - If it reaches TIMEOUT_CYC-1 in WAIT without mul_done: go to HOLD with res_err=1 and res_rx=res_ry=0.
  - The next job's START pulse re-initialises the multiplier.
- Without the macro: no counter is instantiated, res_err is tied to 0, and WAIT lasts indefinitely.

Decomposition:
- From elliptic_curve_structs: P_WIDTH; a point struct {x,y} if the package provides one.
- Add to elliptic_curve_structs: a mul_job_t struct {px, py, k, tag} and the FSM state enum seq_state_t.
- One natural sub-module: job_fifo, a parameterised synchronous FIFO over mul_job_t.

Test Plan (bench uses a stub multiplier: Done rises 20 cycles after the start pulse, R = {Px+k, Py+k}; Done stays high until the next start):
- Single job P=(6,36), k=38, tag=1 -> one mul_start pulse 2 cycles after acceptance; res_valid with R=(44,74), tag=1, err=0.
- Back-to-back jobs (6,36,k=38) then (32,17,k=58) with res_ready=1 -> second start occurs after the first result handshake, with stale Done ignored in BLANK; results (44,74) then (90,75) in order.
- FIFO_DEPTH+2 jobs pushed while res_ready=0 -> job_ready drops after the FIFO fills; no job is lost; all results are released in order once res_ready=1.
- res_ready held low for 50 cycles after a result -> res_valid and data stable throughout; no new mul_start until the handshake.
- reset_n pulsed low while in WAIT -> all outputs at reset values immediately; no result for the abandoned job; a later job completes normally.
- With MUL_WATCHDOG_EN, TIMEOUT_CYC=64, stub never raises Done -> res_valid with res_err=1 and R=(0,0) 64 cycles after START; the next job still completes correctly.
